contrast_box_multi: RTL and testbench

CONTRAST_BOX_MULTI -- requirements
Module: contrast_box_multi

---
 rtl/contrast_box_pkg.sv | 19 +
 rtl/pb_debounce_sync.sv | 47 ++++
 rtl/contrast_box_multi.sv | 178 +++++++++++++++++
 tb/tb_contrast_box_multi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/contrast_box_pkg.sv
// Shared mode encodings and prescaler helper for the multi-channel contrast PWM.
package contrast_box_pkg;

  typedef enum logic [1:0] {
    ModeManual    = 2'b00,
    ModeRamp      = 2'b01,
    ModeTriangle  = 2'b10,
    ModeManualAlt = 2'b11
  } mode_e;

  function automatic int unsigned calc_prescale(input int unsigned clk_hz,
                                                input int unsigned pwm_hz,
                                                input int unsigned cycle);
    int unsigned p;
    p = clk_hz / pwm_hz / (cycle + 1);
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/pb_debounce_sync.sv
// Push-button conditioner: 2-flop synchroniser, stable-count debounce, rising-edge pulse.
module pb_debounce_sync #(
  parameter int unsigned CNTR_WIDTH = 17
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_level;
  logic                  r_rise;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic                  w_done;

  assign w_done  = &r_cnt;
  assign o_level = r_level;
  assign o_rise  = r_rise;

  // The level flips on the 2^N-th consecutive cycle that disagrees with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/contrast_box_multi.sv
// Multi-channel PWM with button-driven and automatic (ramp/triangle) duty control.
module contrast_box_multi
  import contrast_box_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY     = 16000000,
  parameter int unsigned PWM_FREQ            = 1000,
  parameter int unsigned CHANNELS            = 2,
  parameter int unsigned PWM_REG_WIDTH       = 10,
  parameter int unsigned PWM_CYCLE           = 1023,
  parameter int unsigned STEP                = 11,
  parameter int unsigned REPEAT_CYCLES       = 800000,
  parameter int unsigned AUTO_CYCLES         = 8000000,
  parameter int unsigned DEBOUNCE_CNTR_WIDTH = 17,
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              switch_up,
  input  logic                              switch_down,
  input  logic [SEL_W-1:0]                  chan_sel,
  input  logic [1:0]                        mode,
  output logic [CHANNELS-1:0]               pwm,
  output logic [CHANNELS*PWM_REG_WIDTH-1:0] pwm_on_time,
  output logic                              pwm_on_value_changed,
  output logic [SEL_W-1:0]                  changed_chan
);

  localparam int unsigned W        = PWM_REG_WIDTH;
  localparam int unsigned PRESCALE = calc_prescale(CLOCK_FREQUENCY, PWM_FREQ, PWM_CYCLE);
  localparam logic [W:0]  DUTY_MAX = (W+1)'(PWM_CYCLE + 1);

  logic [31:0]               r_presc;
  logic [W-1:0]              r_pwm_cnt;
  logic [CHANNELS-1:0][W:0]  r_target;
  logic [CHANNELS-1:0][W:0]  r_active;
  logic [CHANNELS-1:0]       r_dir;
  logic [31:0]               r_rep;
  logic [31:0]               r_auto;
  logic                      r_changed;
  logic [SEL_W-1:0]          r_changed_chan;

  logic                      w_tick;
  logic                      w_wrap;
  logic                      w_up;
  logic                      w_dn;
  logic                      w_up_rise;
  logic                      w_dn_rise;
  logic                      w_one;
  logic                      w_rep_hit;
  logic                      w_man_step;
  logic                      w_auto_en;
  logic                      w_auto_step;
  mode_e                     w_mode;
  logic [CHANNELS-1:0][W:0]  w_next_target;
  logic [CHANNELS-1:0]       w_next_dir;
  logic                      w_any;
  logic [SEL_W-1:0]          w_low;

  function automatic logic [W:0] sat_inc(input logic [W:0] t);
    logic [W+1:0] s;
    s = {1'b0, t} + (W+2)'(STEP);
    return (s > {1'b0, DUTY_MAX}) ? DUTY_MAX : s[W:0];
  endfunction

  function automatic logic [W:0] sat_dec(input logic [W:0] t);
    return ({1'b0, t} <= (W+2)'(STEP)) ? '0 : t - (W+1)'(STEP);
  endfunction

  pb_debounce_sync #(.CNTR_WIDTH(DEBOUNCE_CNTR_WIDTH)) u_db_up (
    .i_clk   (clk),
    .i_reset (reset),
    .i_btn   (switch_up),
    .o_level (w_up),
    .o_rise  (w_up_rise)
  );

  pb_debounce_sync #(.CNTR_WIDTH(DEBOUNCE_CNTR_WIDTH)) u_db_dn (
    .i_clk   (clk),
    .i_reset (reset),
    .i_btn   (switch_down),
    .o_level (w_dn),
    .o_rise  (w_dn_rise)
  );

  assign w_mode      = mode_e'(mode);
  assign w_tick      = (r_presc == 32'(PRESCALE - 1));
  assign w_wrap      = w_tick && (r_pwm_cnt == W'(PWM_CYCLE));
  assign w_one       = w_up ^ w_dn;
  assign w_rep_hit   = (r_rep == 32'(REPEAT_CYCLES));
  assign w_man_step  = w_one && (w_up_rise || w_dn_rise || w_rep_hit);
  assign w_auto_en   = ((w_mode == ModeRamp) || (w_mode == ModeTriangle)) && !w_up && !w_dn;
  assign w_auto_step = w_auto_en && (r_auto == 32'(AUTO_CYCLES - 1));

  // Triangle turns around on the step taken while sitting at a limit.
  always_comb begin
    w_next_target = r_target;
    w_next_dir    = r_dir;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_man_step && (chan_sel == SEL_W'(k))) begin
        w_next_target[k] = w_up ? sat_inc(r_target[k]) : sat_dec(r_target[k]);
      end else if (w_auto_step) begin
        if (w_mode == ModeTriangle) begin
          if (r_target[k] == DUTY_MAX) begin
            w_next_dir[k] = 1'b0;
          end else if (r_target[k] == '0) begin
            w_next_dir[k] = 1'b1;
          end
          w_next_target[k] = w_next_dir[k] ? sat_inc(r_target[k]) : sat_dec(r_target[k]);
        end else begin
          w_next_target[k] = sat_inc(r_target[k]);
        end
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_low = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_next_target[k] != r_target[k]) begin
        w_any = 1'b1;
        w_low = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc        <= '0;
      r_pwm_cnt      <= '0;
      r_target       <= '0;
      r_active       <= '0;
      r_dir          <= '0;
      r_rep          <= '0;
      r_auto         <= '0;
      r_changed      <= 1'b0;
      r_changed_chan <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 32'd1;
      if (w_tick) begin
        r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + 1'b1;
      end
      if (w_wrap) begin
        r_active <= r_target;
      end
      r_target <= w_next_target;
      r_dir    <= w_next_dir;
      if (!w_one) begin
        r_rep <= '0;
      end else if (w_rep_hit || w_up_rise || w_dn_rise) begin
        r_rep <= 32'd1;
      end else begin
        r_rep <= r_rep + 32'd1;
      end
      if (!w_auto_en || w_auto_step) begin
        r_auto <= '0;
      end else begin
        r_auto <= r_auto + 32'd1;
      end
      r_changed      <= w_any;
      r_changed_chan <= w_low;
    end
  end

  // A full-scale duty (PWM_CYCLE+1) does not fit in W bits, so it reads back as all-ones.
  always_comb begin
    pwm         = '0;
    pwm_on_time = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pwm[k]                 = ({1'b0, r_pwm_cnt} < r_active[k]);
      pwm_on_time[k*W +: W]  = r_active[k][W] ? {W{1'b1}} : r_active[k][W-1:0];
    end
  end

  assign pwm_on_value_changed = r_changed;
  assign changed_chan         = r_changed_chan;

endmodule

// File: tb/tb_contrast_box_multi.sv
// Directed, table-driven bench for contrast_box_multi with small verification parameters.
module tb_contrast_box_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       switch_up;
  logic       switch_down;
  logic [0:0] chan_sel;
  logic [1:0] mode;
  logic [1:0] pwm;
  logic [7:0] pwm_on_time;
  logic       pwm_on_value_changed;
  logic [0:0] changed_chan;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    bit         up;
    bit         dn;
    bit         sel;
    logic [1:0] md;
    int         cyc;
    int         pulses;
    int         t0;
    int         t1;
  } vec_t;

  vec_t vecs[9];
  int   c1_exp[6]   = '{3, 6, 9, 12, 15, 16};
  int   tri_exp[20] = '{3, 6, 9, 12, 15, 16, 13, 10, 7, 4, 1, 0, 3, 6, 9, 12, 15, 16, 13, 10};

  always #5 clk = ~clk;

  contrast_box_multi #(
    .CLOCK_FREQUENCY     (160),
    .PWM_FREQ            (10),
    .CHANNELS            (2),
    .PWM_REG_WIDTH       (4),
    .PWM_CYCLE           (15),
    .STEP                (3),
    .REPEAT_CYCLES       (10),
    .AUTO_CYCLES         (20),
    .DEBOUNCE_CNTR_WIDTH (2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .switch_up            (switch_up),
    .switch_down          (switch_down),
    .chan_sel             (chan_sel),
    .mode                 (mode),
    .pwm                  (pwm),
    .pwm_on_time          (pwm_on_time),
    .pwm_on_value_changed (pwm_on_value_changed),
    .changed_chan         (changed_chan)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_on_value_changed) pulses++;
    end
  endtask

  task automatic wait_pulse(input int limit, output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < limit) begin
      @(negedge clk);
      waited++;
      if (pwm_on_value_changed) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  p1, p2, w, hi0, hi1;
    bit  ok, early;

    vecs[0] = '{"down_ch1",      1'b0, 1'b1, 1'b1, 2'b00,  8, 1, 0, 13};
    vecs[1] = '{"both_held",     1'b1, 1'b1, 1'b1, 2'b00, 40, 0, 0, 13};
    vecs[2] = '{"glitch3",       1'b1, 1'b0, 1'b1, 2'b00,  3, 0, 0, 13};
    vecs[3] = '{"up_ch0",        1'b1, 1'b0, 1'b0, 2'b00,  8, 1, 3, 13};
    vecs[4] = '{"down_ch0_sat",  1'b0, 1'b1, 1'b0, 2'b00, 18, 1, 0, 13};
    vecs[5] = '{"down_at_zero",  1'b0, 1'b1, 1'b0, 2'b00,  8, 0, 0, 13};
    vecs[6] = '{"mode11_manual", 1'b1, 1'b0, 1'b0, 2'b11,  8, 1, 3, 13};
    vecs[7] = '{"ramp_two",      1'b0, 1'b0, 1'b0, 2'b01, 45, 2, 9, 16};
    vecs[8] = '{"held_blk_auto", 1'b1, 1'b0, 1'b1, 2'b01, 30, 0, 9, 16};

    switch_up   = 1'b0;
    switch_down = 1'b0;
    chan_sel    = 1'b0;
    mode        = 2'b00;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_on_time", int'(pwm_on_time), 0);
    check("rst_pulse", int'(pwm_on_value_changed), 0);
    check("rst_chan", int'(changed_chan), 0);
    reset = 1'b0;
    run(10, p1);
    check("idle_pulses", p1, 0);

    // Held up button on channel 1: immediate step, then one per repeat interval.
    chan_sel  = 1'b1;
    switch_up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_pulse((i == 0) ? 20 : 15, w, ok);
      check("c1_timeout", int'(ok), 1);
      check("c1_target", int'(dut.r_target[1]), c1_exp[i]);
      check("c1_chan", int'(changed_chan), 1);
      if (i > 0) check("c1_interval", w, 10);
    end
    run(30, p1);
    check("c1_sat_pulses", p1, 0);
    switch_up = 1'b0;
    run(14, p1);
    check("c1_release_pulses", p1, 0);
    check("c1_ch0_target", int'(dut.r_target[0]), 0);
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
      if (pwm[1]) hi1++;
    end
    check("full_duty_high", hi1, 32);
    check("zero_duty_low", hi0, 0);
    check("on_time_ch1_clamp", int'(pwm_on_time[7:4]), 15);
    check("on_time_ch0", int'(pwm_on_time[3:0]), 0);

    foreach (vecs[v]) begin
      switch_up   = vecs[v].up;
      switch_down = vecs[v].dn;
      chan_sel    = vecs[v].sel;
      mode        = vecs[v].md;
      run(vecs[v].cyc, p1);
      switch_up   = 1'b0;
      switch_down = 1'b0;
      mode        = 2'b00;
      run(14, p2);
      check({vecs[v].name, "_pulses"}, p1 + p2, vecs[v].pulses);
      check({vecs[v].name, "_t0"}, int'(dut.r_target[0]), vecs[v].t0);
      check({vecs[v].name, "_t1"}, int'(dut.r_target[1]), vecs[v].t1);
    end

    // Mid-period target change must not reach pwm until the counter wraps.
    do_reset();
    chan_sel  = 1'b0;
    switch_up = 1'b1;
    wait_pulse(20, w, ok);
    switch_up = 1'b0;
    check("c4_timeout", int'(ok), 1);
    check("c4_active_old", int'(pwm_on_time[3:0]), 0);
    check("c4_pwm_old", int'(pwm[0]), 0);
    early = 1'b0;
    w     = 0;
    while (pwm_on_time[3:0] != 4'd3 && w < 20) begin
      if (pwm[0]) early = 1'b1;
      @(negedge clk);
      w++;
    end
    check("c4_no_early_pwm", int'(early), 0);
    check("c4_load_within_period", int'(w <= 16), 1);
    hi0 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
    end
    check("c4_duty_high", hi0, 3);
    run(10, p1);

    // Triangle: both channels in lockstep, turnaround one step after each limit.
    do_reset();
    mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      wait_pulse(25, w, ok);
      check("c3_timeout", int'(ok), 1);
      check("c3_interval", w, 20);
      check("c3_t0", int'(dut.r_target[0]), tri_exp[i]);
      check("c3_t1", int'(dut.r_target[1]), tri_exp[i]);
      check("c3_chan", int'(changed_chan), 0);
    end

    // Reset in the middle of a ramp.
    mode = 2'b01;
    run(50, p1);
    check("c5_ramp_pulses", p1, 2);
    reset = 1'b1;
    @(negedge clk);
    check("c5_pwm", int'(pwm), 0);
    check("c5_on_time", int'(pwm_on_time), 0);
    check("c5_pulse", int'(pwm_on_value_changed), 0);
    check("c5_chan", int'(changed_chan), 0);
    @(negedge clk);
    reset = 1'b0;
    mode  = 2'b00;
    run(30, p1);
    check("c5_after_pulses", p1, 0);
    check("c5_t0", int'(dut.r_target[0]), 0);

    // Reset mid-press: a still-held button is a new press only after debounce.
    switch_up = 1'b1;
    wait_pulse(20, w, ok);
    check("c5_press_timeout", int'(ok), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_pulse(20, w, ok);
    check("c5_repress_timeout", int'(ok), 1);
    check("c5_repress_debounced", int'(w >= 6), 1);
    check("c5_repress_target", int'(dut.r_target[0]), 3);
    switch_up = 1'b0;
    run(14, p1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
